// File: rtl/mdu_if.sv
// Operand, control and result bundle between the E stage and the multiply/divide unit.
`timescale 1ns/1ps
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (output A, B, MDUOp, Start, Req, input Busy, HI, LO, MDUOut);
  modport slave  (input A, B, MDUOp, Start, Req, output Busy, HI, LO, MDUOut);
endinterface

// File: rtl/mdu.sv
// E-stage multiply/divide unit: the result is computed at launch and held pending,
// then committed to HI/LO when the busy countdown expires.
`timescale 1ns/1ps
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_temp_hi;
  logic [31:0]   r_temp_lo;
  logic          r_wb;

  logic          w_is_md;
  logic          w_is_div;
  logic          w_launch;
  logic          w_div_signed;
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic [31:0]   w_dvd;
  logic [31:0]   w_dvs_mag;
  logic [31:0]   w_dvs;
  logic [31:0]   w_q;
  logic [31:0]   w_r;
  logic [31:0]   w_q_fix;
  logic [31:0]   w_r_fix;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  assign w_is_md  = (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);
  assign w_is_div = (bus.MDUOp == OP_DIV) || (bus.MDUOp == OP_DIVU);
  assign w_launch = bus.Start && w_is_md;

  // Lower 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // One unsigned divider on magnitudes; signs are re-applied afterwards.
  // A zero divisor is replaced by 1 only to keep the datapath defined; that result is never committed.
  assign w_div_signed = (bus.MDUOp == OP_DIV);
  assign w_dvd     = (w_div_signed && bus.A[31]) ? -bus.A : bus.A;
  assign w_dvs_mag = (w_div_signed && bus.B[31]) ? -bus.B : bus.B;
  assign w_dvs     = (bus.B == 32'd0) ? 32'd1 : w_dvs_mag;
  assign w_q       = w_dvd / w_dvs;
  assign w_r       = w_dvd % w_dvs;
  assign w_q_fix   = (w_div_signed && (bus.A[31] ^ bus.B[31])) ? -w_q : w_q;
  assign w_r_fix   = (w_div_signed && bus.A[31]) ? -w_r : w_r;

  always_comb begin
    w_res_hi = w_prod_s[63:32];
    w_res_lo = w_prod_s[31:0];
    case (bus.MDUOp)
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        w_res_hi = w_r_fix;
        w_res_lo = w_q_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_temp_hi <= 32'd0;
      r_temp_lo <= 32'd0;
      r_wb      <= 1'b0;
    end else if (r_busy) begin
      // Commit lands on the same edge Busy drops; mthi/mtlo cannot collide here.
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (r_wb) begin
          r_hi <= r_temp_hi;
          r_lo <= r_temp_lo;
        end
      end
    end else if (!bus.Req) begin
      if (w_launch) begin
        r_temp_hi <= w_res_hi;
        r_temp_lo <= w_res_lo;
        r_cnt     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_busy    <= 1'b1;
        r_wb      <= !(w_is_div && (bus.B == 32'd0));
      end else if (bus.MDUOp == OP_MTHI) begin
        r_hi <= bus.A;
      end else if (bus.MDUOp == OP_MTLO) begin
        r_lo <= bus.A;
      end
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.HI     = r_hi;
  assign bus.LO     = r_lo;
  assign bus.MDUOut = (bus.MDUOp == OP_MFHI) ? r_hi :
                      (bus.MDUOp == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed test-plan sequence with literal expectations, then random
// traffic, all cross-checked every cycle against a cycle-indexed arithmetic model.
`timescale 1ns/1ps
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  mdu_if bus();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model: edge counter, committed HI/LO, the edge index at which the pending op completes.
  int          cyc = 0;
  int          m_done = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [63:0] m_pend = 0;
  bit          m_pend_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Applies the rules of one rising edge to the model, using inputs stable at that edge.
  task automatic model_step();
    bit busy_before;
    busy_before = (cyc < m_done);
    cyc++;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_pend_ok = 0;
    end else begin
      if (cyc == m_done && m_pend_ok) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
      if (!busy_before && !bus.Req) begin
        if (bus.Start && bus.MDUOp >= 1 && bus.MDUOp <= 4) begin
          m_done = cyc + ((bus.MDUOp >= 3) ? DC : MC);
          m_pend_ok = !(bus.MDUOp >= 3 && bus.B == 0);
          m_pend = m_pend_ok ? model_result(bus.MDUOp, bus.A, bus.B) : 64'd0;
        end else if (bus.MDUOp == 5) begin
          m_hi = bus.A;
        end else if (bus.MDUOp == 6) begin
          m_lo = bus.A;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", {31'd0, bus.Busy}, {31'd0, (cyc < m_done)});
      chk("cyc_hi", bus.HI, m_hi);
      chk("cyc_lo", bus.LO, m_lo);
      chk("cyc_mduout", bus.MDUOut,
          (bus.MDUOp == 7) ? m_hi : (bus.MDUOp == 8) ? m_lo : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic start, input logic req);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = start; bus.Req = req;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    set_in(op, a, b, 1'b1, 1'b0);
    tick();
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int launches;
    logic [3:0] op;
    logic st, rq, rs;
    reset = 1'b0;
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset
    repeat (2) tick();
    reset = 1'b1;
    bus.MDUOp = 4'd7;
    #1;
    chk("reset_hi", bus.HI, 32'h0);
    chk("reset_lo", bus.LO, 32'h0);
    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset_mduout", bus.MDUOut, 32'h0);
    $display("reset      : HI=%08h LO=%08h Busy=%0d", bus.HI, bus.LO, bus.Busy);
    cmp_en = 1;
    tick();

    // mult with exact timing of busy and commit
    launch(4'd1, 32'hFFFF_FFFE, 32'd3);
    repeat (4) tick();
    chk("mult_busy_c5", {31'd0, bus.Busy}, 32'd1);
    chk("mult_hi_pending", bus.HI, 32'h0);
    chk("mult_lo_pending", bus.LO, 32'h0);
    tick();
    chk("mult_busy_end", {31'd0, bus.Busy}, 32'd0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    $display("mult       : HI=%08h LO=%08h", bus.HI, bus.LO);

    launch(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("multu_cycles", n, MC);
    chk("multu_hi", bus.HI, 32'h0000_0002);
    chk("multu_lo", bus.LO, 32'hFFFF_FFFA);
    $display("multu      : HI=%08h LO=%08h cycles=%0d", bus.HI, bus.LO, n);

    launch(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, DC);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);
    $display("div        : HI=%08h LO=%08h cycles=%0d", bus.HI, bus.LO, n);

    launch(4'd4, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", bus.LO, 32'd3);
    chk("divu_hi", bus.HI, 32'd1);
    $display("divu       : HI=%08h LO=%08h", bus.HI, bus.LO);

    launch(4'd3, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", bus.HI, 32'd1);
    chk("div0_lo", bus.LO, 32'd3);
    $display("div by 0   : HI=%08h LO=%08h cycles=%0d", bus.HI, bus.LO, n);

    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", bus.LO, 32'h8000_0000);
    chk("divovf_hi", bus.HI, 32'h0);
    $display("div ovf    : HI=%08h LO=%08h", bus.HI, bus.LO);

    // mthi / mtlo / mfhi / mflo
    set_in(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    tick();
    chk("mthi", bus.HI, 32'h1234_5678);
    set_in(4'd6, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b0);
    tick();
    chk("mtlo", bus.LO, 32'hCAFE_BABE);
    bus.MDUOp = 4'd7; #1;
    chk("mfhi", bus.MDUOut, 32'h1234_5678);
    bus.MDUOp = 4'd8; #1;
    chk("mflo", bus.MDUOut, 32'hCAFE_BABE);
    $display("mthi/mtlo  : HI=%08h LO=%08h", bus.HI, bus.LO);

    launch(4'd2, 32'd1, 32'd1);
    set_in(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    tick();
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mthi_busy_ignored", bus.HI, 32'h1234_5678);
    wait_idle(n);
    chk("multu11_hi", bus.HI, 32'd0);
    chk("multu11_lo", bus.LO, 32'd1);
    $display("mthi busy  : HI=%08h LO=%08h", bus.HI, bus.LO);

    // Req suppression
    set_in(4'd1, 32'd2, 32'd3, 1'b1, 1'b1);
    tick();
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("req_launch_busy", {31'd0, bus.Busy}, 32'd0);
    repeat (6) tick();
    chk("req_launch_lo", bus.LO, 32'd1);
    $display("req mult   : Busy=%0d LO=%08h", bus.Busy, bus.LO);

    launch(4'd4, 32'd100, 32'd7);
    repeat (2) tick();
    bus.Req = 1'b1;
    wait_idle(n);
    bus.Req = 1'b0;
    chk("req_inflight_cycles", n, DC - 2);
    chk("req_inflight_lo", bus.LO, 32'd14);
    chk("req_inflight_hi", bus.HI, 32'd2);
    $display("req div    : HI=%08h LO=%08h", bus.HI, bus.LO);

    set_in(4'd6, 32'h5555_5555, 32'd0, 1'b0, 1'b1);
    tick();
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("req_mtlo", bus.LO, 32'd14);
    $display("req mtlo   : LO=%08h", bus.LO);

    // Reset during an operation discards it
    launch(4'd1, 32'd7, 32'd6);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    reset = 1'b1;
    repeat (8) tick();
    chk("rst_mid_nocommit", bus.LO, 32'd0);
    $display("reset mid  : HI=%08h LO=%08h", bus.HI, bus.LO);

    // Random traffic honouring the stall contract (no Start while busy)
    launches = 0;
    for (int i = 0; i < 2000; i++) begin
      op = 4'($urandom_range(0, 15));
      st = 1'b0;
      if (!(cyc < m_done))
        st = (op >= 1 && op <= 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      rq = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) != 0);
      set_in(op, pick_operand(), pick_operand(), st, rq);
      reset = rs;
      if (st && rs && !rq && op >= 1 && op <= 4) launches++;
      tick();
    end
    reset = 1'b1;
    set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (12) tick();
    $display("random     : %0d launches over 2000 cycles", launches);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- E-stage multiply/divide unit for the P7 pipeline.
- Takes the same forwarded E-stage operands as the ALU and runs mult/multu/div/divu as multi-cycle operations, holding the results in architectural HI/LO registers.
- Writes HI/LO directly for mthi/mtlo.
- Drives the mfhi/mflo read value, which the E-stage result mux selects into the E/M register in place of the ALU result.
- Reports Busy so the hazard unit can stall D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-low: state clears on a rising clk edge while reset==0.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- Start  input  1  E-stage instruction is mult/multu/div/divu this cycle.
- Req  input  1  interrupt/exception request from the CP0 unit; suppresses any new HI/LO effect this cycle.
- Busy  output  1  multi-cycle operation in progress.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- MDUOut  output  32  read value for mfhi/mflo.

Behaviour:
- Reset (reset==0 at a clk edge): HI=0, LO=0, Busy=0, cycle counter=0, pending results cleared.
  - Overrides everything, including an operation in flight, which is discarded with no HI/LO write.
- Launch condition: Start==1, MDUOp in 1..4, Busy==0, Req==0.
  - On that clk edge, compute and latch the pending result into internal tempHI/tempLO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy goes 1 from the next cycle.
- Start with MDUOp outside 1..4: ignored.
- Start while Busy==1: ignored; the hazard unit guarantees this does not occur.
- Busy timing:
  - Busy is registered and stays 1 for exactly N cycles (N = the loaded count).
  - The counter decrements each edge while Busy.
  - On the edge where the counter goes 1->0: Busy->0 and HI/LO<=tempHI/tempLO in the same edge.
  - HI/LO therefore update N cycles after the launch edge.
- Stall contract: the hazard unit stalls on (Start | Busy) whenever the D-stage instruction uses the MDU. The unit itself never stalls.
- mult: {HI,LO} = signed(A) * signed(B), 64-bit product.
- multu: {HI,LO} = unsigned product.
- div (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (B==0): the full DIV_CYCLES busy period still runs; HI/LO keep their previous values at commit.
- mthi/mtlo:
  - When MDUOp is 5/6, Busy==0 and Req==0: HI<=A or LO<=A on the next edge, Busy unaffected.
  - Ignored while Busy==1.
- Req handling:
  - Req suppresses only a launch or an mthi/mtlo in the same cycle.
  - An operation already in flight (Busy==1) continues and commits; its instruction has already left E.
- MDUOut: combinational.
  - MDUOp==7 gives HI, MDUOp==8 gives LO, otherwise 0.
  - It reflects the committed HI/LO, never the pending temp values.
- A commit edge and an mthi/mtlo edge cannot coincide, because mthi/mtlo are ignored while Busy==1.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> HI=0, LO=0, Busy=0, MDUOut=0 with MDUOp=7.
2. mult: A=0xFFFFFFFE (-2), B=3, Start=1 for 1 cycle.
   - Busy=1 for exactly 5 cycles.
   - HI/LO unchanged until the 5th edge after launch, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
   - Repeat with multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. div: A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu on A=7, B=2 -> LO=3, HI=1.
   - div with B=0 -> Busy 10 cycles, HI/LO unchanged.
4. mthi/mtlo/mf:
   - MDUOp=5, A=0x12345678 -> next cycle HI=0x12345678.
   - MDUOp=6, A=0xCAFEBABE -> LO updated.
   - MDUOp=7 -> MDUOut=0x12345678; MDUOp=8 -> MDUOut=0xCAFEBABE.
   - mthi issued while Busy=1 -> HI unchanged.
5. Req:
   - Start=1 for mult with Req=1 -> Busy stays 0, HI/LO unchanged.
   - Launch a div, then assert Req at busy cycle 3 -> div still commits at cycle 10.
   - mtlo with Req=1 -> LO unchanged.
6. Reset mid-operation: launch mult, drive reset=0 at busy cycle 2 -> next edge Busy=0, HI=LO=0, and no later commit occurs.
